// File: rtl/ysyx_22050612_lsu_if.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_lsu_if
// Bundles the three handshaked channels around the load/store unit:
//   in_*        : operation from EXU (valid/ready)
//   mem_req_*   : aligned request to memory (valid/ready)
//   mem_resp_*  : one-cycle response/ack from memory
//   out_*       : result to writeback (valid/ready)
// Modports:
//   master : the LSU view (drives in_ready, mem_req_*, out_*)
//   slave  : the surrounding pipeline/memory view
// ---------------------------------------------------------------------------
interface ysyx_22050612_lsu_if #(
  parameter int XLEN = 64
) ();
  logic              in_valid;
  logic              in_ready;
  logic              in_store;
  logic [1:0]        in_size;
  logic              in_unsigned;
  logic [XLEN-1:0]   in_addr;
  logic [XLEN-1:0]   in_wdata;
  logic [4:0]        in_rd;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [XLEN-1:0]   mem_req_addr;
  logic              mem_req_wen;
  logic [XLEN-1:0]   mem_req_wdata;
  logic [XLEN/8-1:0] mem_req_wmask;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_resp_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_rd;
  logic [XLEN-1:0]   out_data;
  logic              out_gpr_wen;
  logic              out_err;

  modport master (
    input  in_valid, in_store, in_size, in_unsigned, in_addr, in_wdata, in_rd,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, out_ready,
    output in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
    output mem_req_wmask, out_valid, out_rd, out_data, out_gpr_wen, out_err
  );

  modport slave (
    output in_valid, in_store, in_size, in_unsigned, in_addr, in_wdata, in_rd,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, out_ready,
    input  in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
    input  mem_req_wmask, out_valid, out_rd, out_data, out_gpr_wen, out_err
  );
endinterface

// File: rtl/ysyx_22050612_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_lsu
// Multi-cycle load/store unit. Accepts one operation at a time from EXU,
// issues a single XLEN-aligned memory request, waits for the response and
// hands sign/zero-extended load data (or a store ack) to writeback.
// Misaligned / illegal-size operations and response timeouts finish with
// out_err=1 and out_data=0 without touching memory.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   lsu_bus : ysyx_22050612_lsu_if.master (EXU, memory and writeback channels)
// Parameters:
//   XLEN    : 32 or 64
//   TIMEOUT : cycles from REQ entry to give up waiting; 0 disables
// ---------------------------------------------------------------------------
module ysyx_22050612_lsu #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  rst,
  ysyx_22050612_lsu_if.master  lsu_bus
);

  localparam int NB     = XLEN / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int CNT_W  = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Byte-enable mask for an access of 2^size bytes starting at byte lane.
  function automatic logic [NB-1:0] lane_mask(input logic [1:0] size,
                                              input logic [LANE_W-1:0] lane);
    logic [15:0] m;
    m = (16'd1 << (5'd1 << size)) - 16'd1;
    m = m << lane;
    return m[NB-1:0];
  endfunction

  // Address is misaligned when any of its low size bits are set.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [LANE_W-1:0] lane);
    logic [LANE_W-1:0] amask;
    amask = LANE_W'((4'd1 << size) - 4'd1);
    return (lane & amask) != {LANE_W{1'b0}};
  endfunction

  // Move the addressed bytes to bit 0, then extend from 8<<size bits by
  // pushing them to the top and shifting back (arithmetic for sign-extend).
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0]   rdata,
                                               input logic [LANE_W-1:0] lane,
                                               input logic [1:0]        size,
                                               input logic              uns);
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] left;
    logic [6:0]      sh;
    raw  = rdata >> {lane, 3'b000};
    sh   = 7'(XLEN) - (7'd8 << size);
    left = raw << sh;
    if (uns && (size != 2'd3)) begin
      return left >> sh;
    end else begin
      return $unsigned($signed(left) >>> sh);
    end
  endfunction

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
  logic [NB-1:0]     req_wmask_q, req_wmask_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              err_q, err_d;
  logic              gwen_q, gwen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [LANE_W-1:0] in_lane_s;
  logic              in_bad_s;
  logic [CNT_W-1:0]  cnt_step_s;
  logic              timeout_hit_s;

  assign in_lane_s = lsu_bus.in_addr[LANE_W-1:0];

  // Operation rejection and timeout detection.
  always_comb begin
    in_bad_s = is_misaligned(lsu_bus.in_size, in_lane_s);
    if ((XLEN == 32) && (lsu_bus.in_size == 2'd3)) begin
      in_bad_s = 1'b1;
    end else begin
      in_bad_s = in_bad_s;
    end
    if (TIMEOUT == 0) begin
      cnt_step_s    = cnt_q;
      timeout_hit_s = 1'b0;
    end else begin
      cnt_step_s    = cnt_q + CNT_W'(1);
      timeout_hit_s = (cnt_step_s >= TO_LIMIT);
    end
  end

  // Next-state and datapath-register update for the IDLE/REQ/WAIT/DONE FSM.
  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    rd_d        = rd_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wmask_d = req_wmask_q;
    data_d      = data_q;
    err_d       = err_q;
    gwen_d      = gwen_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (lsu_bus.in_valid) begin
          store_d     = lsu_bus.in_store;
          size_d      = lsu_bus.in_size;
          uns_d       = lsu_bus.in_unsigned;
          lane_d      = in_lane_s;
          rd_d        = lsu_bus.in_rd;
          req_addr_d  = {lsu_bus.in_addr[XLEN-1:LANE_W], {LANE_W{1'b0}}};
          req_wdata_d = lsu_bus.in_wdata << {in_lane_s, 3'b000};
          data_d      = {XLEN{1'b0}};
          gwen_d      = 1'b0;
          cnt_d       = {CNT_W{1'b0}};
          if (lsu_bus.in_store) begin
            req_wmask_d = lane_mask(lsu_bus.in_size, in_lane_s);
          end else begin
            req_wmask_d = {NB{1'b0}};
          end
          if (in_bad_s) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        cnt_d = cnt_step_s;
        // A completed handshake wins over a timeout in the same cycle.
        if (lsu_bus.mem_req_ready) begin
          state_d = S_WAIT;
        end else if (timeout_hit_s) begin
          err_d   = 1'b1;
          data_d  = {XLEN{1'b0}};
          state_d = S_DONE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_step_s;
        if (lsu_bus.mem_resp_valid) begin
          if (store_q) begin
            data_d = {XLEN{1'b0}};
            gwen_d = 1'b0;
          end else begin
            data_d = load_ext(lsu_bus.mem_resp_rdata, lane_q, size_q, uns_q);
            gwen_d = (rd_q != 5'd0);
          end
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (timeout_hit_s) begin
          err_d   = 1'b1;
          data_d  = {XLEN{1'b0}};
          gwen_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        // Result fields return to zero once writeback takes them.
        if (lsu_bus.out_ready) begin
          data_d  = {XLEN{1'b0}};
          err_d   = 1'b0;
          gwen_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      lane_q      <= {LANE_W{1'b0}};
      rd_q        <= 5'd0;
      req_addr_q  <= {XLEN{1'b0}};
      req_wdata_q <= {XLEN{1'b0}};
      req_wmask_q <= {NB{1'b0}};
      data_q      <= {XLEN{1'b0}};
      err_q       <= 1'b0;
      gwen_q      <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      rd_q        <= rd_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wmask_q <= req_wmask_d;
      data_q      <= data_d;
      err_q       <= err_d;
      gwen_q      <= gwen_d;
      cnt_q       <= cnt_d;
    end
  end

  assign lsu_bus.in_ready      = (state_q == S_IDLE);
  assign lsu_bus.mem_req_valid = (state_q == S_REQ);
  assign lsu_bus.mem_req_addr  = req_addr_q;
  assign lsu_bus.mem_req_wen   = store_q;
  assign lsu_bus.mem_req_wdata = req_wdata_q;
  assign lsu_bus.mem_req_wmask = req_wmask_q;
  assign lsu_bus.out_valid     = (state_q == S_DONE);
  assign lsu_bus.out_rd        = rd_q;
  assign lsu_bus.out_data      = data_q;
  assign lsu_bus.out_gpr_wen   = gwen_q;
  assign lsu_bus.out_err       = err_q;

endmodule

// File: tb/tb_ysyx_22050612_lsu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050612_lsu
// Directed bench for the LSU (XLEN=64, TIMEOUT=8). Inputs are driven and
// outputs sampled 1 time unit after the rising clock edge.
// ---------------------------------------------------------------------------
module tb_ysyx_22050612_lsu;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  int   n_done;

  ysyx_22050612_lsu_if #(.XLEN(64)) bus ();

  ysyx_22050612_lsu #(.XLEN(64), .TIMEOUT(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .lsu_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completed writeback handshakes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_done <= 0;
    end else if (bus.out_valid && bus.out_ready) begin
      n_done <= n_done + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic st, input logic [1:0] sz, input logic u,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd);
    bus.in_store    = st;
    bus.in_size     = sz;
    bus.in_unsigned = u;
    bus.in_addr     = addr;
    bus.in_wdata    = wd;
    bus.in_rd       = rd;
    bus.in_valid    = 1'b1;
    step();
    bus.in_valid    = 1'b0;
  endtask

  // One operation at minimum latency: accept at T, req at T+1, resp at T+2,
  // result at T+3, back to IDLE at T+4.
  task automatic run_op(input string tag, input logic st, input logic [1:0] sz,
                        input logic u, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [4:0] rd, input logic [63:0] rdata,
                        input logic [7:0] exp_mask, input logic [63:0] exp_wd,
                        input logic [63:0] exp_data, input logic exp_gwen);
    bus.mem_req_ready = 1'b1;
    bus.out_ready     = 1'b1;
    present(st, sz, u, addr, wd, rd);
    check_eq({tag, ".req_valid"}, 64'(bus.mem_req_valid), 64'd1);
    check_eq({tag, ".in_ready_busy"}, 64'(bus.in_ready), 64'd0);
    check_eq({tag, ".req_addr"}, bus.mem_req_addr, addr & ~64'h7);
    check_eq({tag, ".req_wen"}, 64'(bus.mem_req_wen), 64'(st));
    check_eq({tag, ".req_wmask"}, 64'(bus.mem_req_wmask), 64'(exp_mask));
    if (st) begin
      check_eq({tag, ".req_wdata"}, bus.mem_req_wdata, exp_wd);
    end
    step();
    check_eq({tag, ".wait_no_valid"}, 64'(bus.out_valid), 64'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = rdata;
    step();
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = 64'd0;
    check_eq({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
    check_eq({tag, ".out_data"}, bus.out_data, exp_data);
    check_eq({tag, ".gpr_wen"}, 64'(bus.out_gpr_wen), 64'(exp_gwen));
    check_eq({tag, ".out_rd"}, 64'(bus.out_rd), 64'(rd));
    check_eq({tag, ".out_err"}, 64'(bus.out_err), 64'd0);
    step();
    check_eq({tag, ".idle_ready"}, 64'(bus.in_ready), 64'd1);
    check_eq({tag, ".idle_no_valid"}, 64'(bus.out_valid), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic        u;
    logic [63:0] addr;
    logic [4:0]  rd;
    logic [63:0] rdata;
    logic [63:0] exp;
    logic        gwen;
  } load_vec_t;

  load_vec_t lv[5];

  initial begin
    int          k;
    int          done0;
    logic [63:0] held;
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    bus.in_valid       = 1'b0;
    bus.in_store       = 1'b0;
    bus.in_size        = 2'd0;
    bus.in_unsigned    = 1'b0;
    bus.in_addr        = 64'd0;
    bus.in_wdata       = 64'd0;
    bus.in_rd          = 5'd0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = 64'd0;
    bus.out_ready      = 1'b1;

    // byte lane 3 of 0x80FF0000 is 0x80, lane 2 is 0xFF
    lv[0] = '{2'd0, 1'b0, 64'h8000_0003, 5'd5,  64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80, 1'b1};
    lv[1] = '{2'd0, 1'b1, 64'h8000_0002, 5'd6,  64'h0000_0000_80FF_0000, 64'h0000_0000_0000_00FF, 1'b1};
    lv[2] = '{2'd1, 1'b0, 64'h8000_0002, 5'd0,  64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_80FF, 1'b0};
    lv[3] = '{2'd2, 1'b0, 64'h8000_0004, 5'd9,  64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 1'b1};
    lv[4] = '{2'd3, 1'b1, 64'h8000_0008, 5'd10, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF, 1'b1};

    #12;
    check_eq("rst.in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst.req_valid", 64'(bus.mem_req_valid), 64'd0);
    check_eq("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst.out_err", 64'(bus.out_err), 64'd0);
    check_eq("rst.gpr_wen", 64'(bus.out_gpr_wen), 64'd0);
    check_eq("rst.out_data", bus.out_data, 64'd0);
    check_eq("rst.req_wmask", 64'(bus.mem_req_wmask), 64'd0);
    rst = 1'b0;
    step();

    // Loads of every size, signed and unsigned, including rd=0.
    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("load%0d", i), 1'b0, lv[i].sz, lv[i].u, lv[i].addr, 64'd0,
             lv[i].rd, lv[i].rdata, 8'h00, 64'd0, lv[i].exp, lv[i].gwen);
    end

    // Store half into lane 6.
    run_op("sh", 1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_1234, 5'd4,
           64'd0, 8'hC0, 64'h1234_0000_0000_0000, 64'd0, 1'b0);

    // Misaligned word: error one cycle after accept, no memory request.
    present(1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'd0, 5'd7);
    check_eq("mis.out_valid", 64'(bus.out_valid), 64'd1);
    check_eq("mis.out_err", 64'(bus.out_err), 64'd1);
    check_eq("mis.req_valid", 64'(bus.mem_req_valid), 64'd0);
    check_eq("mis.out_data", bus.out_data, 64'd0);
    check_eq("mis.gpr_wen", 64'(bus.out_gpr_wen), 64'd0);
    step();
    check_eq("mis.req_valid_after", 64'(bus.mem_req_valid), 64'd0);
    check_eq("mis.idle", 64'(bus.in_ready), 64'd1);

    // Backpressure on both the request and writeback sides.
    done0 = n_done;
    bus.mem_req_ready = 1'b0;
    present(1'b1, 2'd2, 1'b0, 64'h8000_0014, 64'h0000_0000_CAFE_BABE, 5'd8);
    for (int c = 0; c < 4; c++) begin
      check_eq("bp.req_valid", 64'(bus.mem_req_valid), 64'd1);
      check_eq("bp.req_addr", bus.mem_req_addr, 64'h8000_0010);
      check_eq("bp.req_wdata", bus.mem_req_wdata, 64'hCAFE_BABE_0000_0000);
      check_eq("bp.req_wmask", 64'(bus.mem_req_wmask), 64'hF0);
      check_eq("bp.in_ready", 64'(bus.in_ready), 64'd0);
      if (c < 3) begin
        step();
      end
    end
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    bus.out_ready = 1'b0;
    bus.mem_resp_valid = 1'b1;
    step();
    bus.mem_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_eq("bp.out_valid_held", 64'(bus.out_valid), 64'd1);
      check_eq("bp.out_data_held", bus.out_data, 64'd0);
      check_eq("bp.in_ready_done", 64'(bus.in_ready), 64'd0);
      step();
    end
    check_eq("bp.out_valid_last", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    step();
    check_eq("bp.completions", 64'(n_done - done0), 64'd1);
    check_eq("bp.idle", 64'(bus.in_ready), 64'd1);

    // Timeout: no response, error exactly 8 cycles after REQ entry.
    done0 = n_done;
    bus.mem_req_ready = 1'b1;
    bus.out_ready = 1'b1;
    present(1'b0, 2'd2, 1'b0, 64'h8000_0010, 64'd0, 5'd11);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      step();
      k++;
    end
    check_eq("to.cycles", 64'(k), 64'd8);
    check_eq("to.out_err", 64'(bus.out_err), 64'd1);
    check_eq("to.out_data", bus.out_data, 64'd0);
    check_eq("to.gpr_wen", 64'(bus.out_gpr_wen), 64'd0);
    step();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'h1111_2222_3333_4444;
    step();
    bus.mem_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_eq("to.stray_ignored", 64'(bus.out_valid), 64'd0);
      step();
    end
    check_eq("to.completions", 64'(n_done - done0), 64'd1);

    // Reset pulsed while waiting for a response.
    present(1'b0, 2'd3, 1'b0, 64'h8000_0018, 64'd0, 5'd12);
    step();
    check_eq("rw.in_wait", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check_eq("rw.in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rw.req_valid", 64'(bus.mem_req_valid), 64'd0);
    check_eq("rw.out_valid", 64'(bus.out_valid), 64'd0);
    #2;
    rst = 1'b0;
    step();
    run_op("lwu", 1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'd0, 5'd3,
           64'h8000_0001_0000_0000, 8'h00, 64'd0, 64'h0000_0000_8000_0001, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
